// File: rtl/reg_file.sv
// Register file with four continuously exposed control entries (op_a, op_b, uart_config, div_ratio).
// Optional REGFILE_WR_FWD_EN: a read colliding with a write returns the write data.
module reg_file #(
  parameter int data_width = 8,
  parameter int addr_bits  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_bits-1:0]  address,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] rddata,
  output logic                  rddata_vld,
  output logic                  wr_done,
  output logic [data_width-1:0] op_a,
  output logic [data_width-1:0] op_b,
  output logic [data_width-1:0] uart_config,
  output logic [data_width-1:0] div_ratio
);

  localparam int depth = 2 ** addr_bits;

  logic [data_width-1:0] mem [depth];

  // Entry 2: parity on, even parity, prescale 32. Entry 3: divide ratio 32.
  function automatic logic [data_width-1:0] reset_val(input int idx);
    case (idx)
      2:       return data_width'(8'h81);
      3:       return data_width'(8'h20);
      default: return '0;
    endcase
  endfunction

  // Strobe semantics: wr_en/rd_en are sampled every edge with no backpressure;
  // wr_done and rddata_vld are single-cycle strobes one cycle after the request,
  // and stay high for consecutive cycles when requests are issued back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem[i] <= reset_val(i);
      rddata     <= '0;
      rddata_vld <= 1'b0;
      wr_done    <= 1'b0;
    end else begin
      wr_done <= wr_en;
      if (wr_en) mem[address] <= wr_data;
`ifdef REGFILE_WR_FWD_EN
      if (wr_en && rd_en) begin
        rddata     <= wr_data;
        rddata_vld <= 1'b1;
      end else if (rd_en) begin
        rddata     <= mem[address];
        rddata_vld <= 1'b1;
      end else begin
        rddata_vld <= 1'b0;
      end
`else
      // Write has priority; a colliding read is dropped and rddata holds.
      if (rd_en && !wr_en) rddata <= mem[address];
      rddata_vld <= rd_en && !wr_en;
`endif
    end
  end

  assign op_a        = mem[0];
  assign op_b        = mem[1];
  assign uart_config = mem[2];
  assign div_ratio   = mem[3];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: driver pushes expected strobes/read data, negedge monitor checks them.
// Build with REGFILE_WR_FWD_EN defined to exercise the collision-forwarding variant.
module tb_reg_file;

  logic       clk;
  logic       rst;
  logic [3:0] address;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rddata;
  logic       rddata_vld;
  logic       wr_done;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] uart_config;
  logic [7:0] div_ratio;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         wr_cnt = 0;

  bit         pend_rd = 0;
  bit         pend_wr = 0;
  logic [7:0] pend_data = '0;

  reg_file #(.data_width(8), .addr_bits(4)) dut (
    .clk(clk), .rst(rst), .address(address), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rddata(rddata), .rddata_vld(rddata_vld), .wr_done(wr_done),
    .op_a(op_a), .op_b(op_b), .uart_config(uart_config), .div_ratio(div_ratio)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Requests sampled at the previous edge become due now.
  task automatic flush_pending();
    if (pend_rd) exp_q.push_back(pend_data);
    if (pend_wr) wr_cnt++;
    pend_rd = 0;
    pend_wr = 0;
  endtask

  task automatic drive(input bit we, input bit re, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] exp_rd);
    @(posedge clk);
    flush_pending();
    #1;
    wr_en   = we;
    rd_en   = re;
    address = a;
    wr_data = d;
    pend_wr = we;
`ifdef REGFILE_WR_FWD_EN
    pend_rd   = re;
    pend_data = we ? d : exp_rd;
`else
    pend_rd   = re && !we;
    pend_data = exp_rd;
`endif
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_vld", {7'b0, rddata_vld}, {7'b0, exp_q.size() != 0});
      if (rddata_vld && exp_q.size() != 0) check("rddata", rddata, exp_q.pop_front());
      check("wr_done", {7'b0, wr_done}, {7'b0, wr_cnt != 0});
      if (wr_cnt != 0) wr_cnt--;
    end
  end

  initial begin
    rst = 1'b1; wr_en = 0; rd_en = 0; address = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_op_a", op_a, 8'h00);
    check("rst_op_b", op_b, 8'h00);
    check("rst_uart", uart_config, 8'h81);
    check("rst_div", div_ratio, 8'h20);
    check("rst_vld", {7'b0, rddata_vld}, 8'h00);
    check("rst_wr_done", {7'b0, wr_done}, 8'h00);
    check("rst_rddata", rddata, 8'h00);

    drive(0, 1, 4'd7, 8'h00, 8'h00);
    idle();

    // Write then read back; read immediately after a write sees new data.
    drive(1, 0, 4'd9, 8'hA5, 8'h00);
    drive(0, 1, 4'd9, 8'h00, 8'hA5);
    idle();
    idle();

    // Mapped outputs
    drive(1, 0, 4'd0, 8'h3C, 8'h00);
    idle();
    check("op_a", op_a, 8'h3C);
    drive(1, 0, 4'd1, 8'h05, 8'h00);
    idle();
    check("op_b", op_b, 8'h05);
    check("op_a_hold", op_a, 8'h3C);

    // Back-to-back writes: wr_done held for two cycles
    drive(1, 0, 4'd3, 8'h44, 8'h00);
    drive(1, 0, 4'd3, 8'h20, 8'h00);
    idle();
    check("div_ratio", div_ratio, 8'h20);

    // Streaming read
    drive(0, 1, 4'd3, 8'h00, 8'h20);
    drive(0, 1, 4'd3, 8'h00, 8'h20);
    drive(0, 1, 4'd3, 8'h00, 8'h20);
    idle();
    idle();
    check("rddata_hold", rddata, 8'h20);

    // Interleaved different addresses
    drive(1, 0, 4'd12, 8'hC3, 8'h00);
    drive(0, 1, 4'd9, 8'h00, 8'hA5);
    drive(0, 1, 4'd12, 8'h00, 8'hC3);
    idle();

    // Collision on address 5
    drive(1, 1, 4'd5, 8'h7E, 8'h00);
    idle();
    idle();
`ifndef REGFILE_WR_FWD_EN
    check("collide_hold", rddata, 8'hC3);
`endif
    drive(0, 1, 4'd5, 8'h00, 8'h7E);
    idle();
    idle();

    // Reset asserted mid-cycle while a write to address 2 is presented
    @(posedge clk);
    flush_pending();
    #1;
    wr_en = 1; address = 4'd2; wr_data = 8'h55;
    #2 rst = 1'b1;
    #1;
    check("async_op_a", op_a, 8'h00);
    check("async_op_b", op_b, 8'h00);
    check("async_uart", uart_config, 8'h81);
    @(posedge clk);
    #1;
    check("rstw_uart", uart_config, 8'h81);
    check("rstw_wr_done", {7'b0, wr_done}, 8'h00);
    wr_en = 0;
    rst = 1'b0;
    idle();
    idle();
    check("post_uart", uart_config, 8'h81);
    drive(0, 1, 4'd9, 8'h00, 8'h00);
    idle();
    idle();

    check("q_empty", 8'(exp_q.size()), 8'h00);
    check("wr_cnt_zero", 8'(wr_cnt), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_file.md
# reg_file

Register file between the system controller and the datapath. Write and read requests arrive on one shared address bus; a write is acknowledged with `wr_done` and a read returns registered data with `rddata_vld`. The file exposes four fixed-location registers continuously: ALU operand A, ALU operand B, UART configuration and clock-divider ratio. These feed the ALU, UART and clock divider directly.

## Interface
- `data_width`, default 8: register width.
- `addr_bits`, default 4: address width; depth = 2**addr_bits entries.

Ports:
- `clk`  in  1: system clock; all state is updated on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `address`  in  addr_bits: target entry for a read or a write.
- `wr_en`  in  1: write request, sampled each cycle.
- `wr_data`  in  data_width: write data.
- `rd_en`  in  1: read request, sampled each cycle.
- `rddata`  out  data_width: registered read data.
- `rddata_vld`  out  1: `rddata` is valid this cycle.
- `wr_done`  out  1: one-cycle write acknowledge.
- `op_a`  out  data_width: entry 0, continuously driven.
- `op_b`  out  data_width: entry 1, continuously driven.
- `uart_config`  out  data_width: entry 2.
  - bit0: parity enable.
  - bit1: parity type (0 = even).
  - bits[7:2]: prescale.
- `div_ratio`  out  data_width: entry 3, continuously driven.

## Operation
- Storage is 2**addr_bits flops of width data_width. There is no out-of-range address; every address hits an entry.
- Reset values:
  - Entry 2 resets to 8'h81 (parity on, even, prescale 32).
  - Entry 3 resets to 8'h20 (ratio 32).
  - All other entries reset to 0.
  - `rddata` = 0, `rddata_vld` = 0, `wr_done` = 0.
- Write:
  - `wr_en`=1 at an edge stores `wr_data` at `address` on that edge.
  - `wr_done`=1 for the following cycle only.
  - If `wr_en` stays high for N consecutive cycles, N writes occur and `wr_done` stays high for N cycles, delayed one cycle.
- Read:
  - `rd_en`=1 and `wr_en`=0 at an edge loads `rddata` with mem[`address`].
  - `rddata_vld`=1 for the following cycle.
  - `rd_en` held high gives a new read every cycle, with `rddata_vld` continuously high one cycle delayed.
- Idle cycles: when there is no read, `rddata` holds its last value and `rddata_vld`=0.
- Simultaneous `wr_en`=1 and `rd_en`=1: the write wins. Behaviour is given under Configuration.
- Mapped outputs `op_a`, `op_b`, `uart_config` and `div_ratio` are direct flop outputs. They reflect a write from the cycle after the write edge.
- Reset mid-operation: the asynchronous reset immediately restores every reset value and clears both strobes. A write on the reset-release edge is not taken while `rst` is high.

## Timing
- Write latency:
  - Storage updates at edge E.
  - `wr_done` and mapped outputs change after E and are visible in cycle E+1.
- Read latency is 1 cycle: request at edge E, `rddata`/`rddata_vld` valid in cycle E+1.
- There is no combinational path from any input to any output.
- Back-to-back operations:
  - Write to X at edge E, then read X at edge E+1: the read returns the new value.
  - Read and write to different addresses in successive cycles are independent.

## Configuration
- Macro `REGFILE_WR_FWD_EN`, defined:
  - Simultaneous `wr_en`=1 and `rd_en`=1 performs the write.
  - It also returns `wr_data` on `rddata` with `rddata_vld`=1 in the next cycle, alongside `wr_done`=1.
- Undefined:
  - The read is dropped.
  - `rddata` holds its value, `rddata_vld`=0 next cycle, and only `wr_done`=1.

## Test plan
- Reset values: assert `rst` mid-cycle, then release → `op_a`=0, `op_b`=0, `uart_config`=8'h81, `div_ratio`=8'h20, `rddata_vld`=0, `wr_done`=0; read of address 7 returns 0.
- Write/readback: write 8'hA5 to address 9 → `wr_done` high exactly 1 cycle. Read address 9 → `rddata`=8'hA5 with `rddata_vld` in the next cycle.
- Mapped outputs: write 8'h3C to address 0 and 8'h05 to address 1 → `op_a`=8'h3C and `op_b`=8'h05 in the cycle after each write edge.
- Streaming read: hold `rd_en` for 3 cycles on address 3 → `rddata_vld` high for 3 cycles delayed by 1, each beat carrying 8'h20.
- Collision: `wr_en`=`rd_en`=1, address 5, data 8'h7E.
  - With `REGFILE_WR_FWD_EN`: `rddata`=8'h7E and `rddata_vld`=1.
  - Without: `rddata_vld`=0.
  - In both builds `wr_done`=1 and mem[5]=8'h7E.
- Reset mid-write: assert `rst` while `wr_en`=1 targets address 2 → `uart_config` stays 8'h81 and `wr_done` stays 0.
